seq_restoring_divider: RTL and testbench

//  Iterative restoring divider: divides 2W-bit dividend by W-bit divisor, giving W-bit quotient + W-bit remainder.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 34 +++
 rtl/seq_restoring_divider.sv | 135 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_W       default divisor / quotient / remainder width (dividend is 2*DIV_W)
//   DIV_CNT_W   default iteration-counter width; 2**DIV_CNT_W must exceed DIV_W
//   div_state_t controller states
package div_pkg;

    localparam int DIV_W     = 8;
    localparam int DIV_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step, purely combinational.
//   r       in   W    partial remainder, always < d on entry
//   bit_in  in   1    next dividend bit shifted into the remainder
//   d       in   W    divisor
//   r_next  out  W    partial remainder after the trial subtraction
//   qbit    out  1    quotient bit produced by this step
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] r,
    input  logic         bit_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] r_next,
    output logic         qbit
);

    logic [W:0] trial;
    logic [W:0] diff;

    assign trial = {r, bit_in};
    assign diff  = trial - {1'b0, d};

    // r < d on entry means trial < 2*d, so a successful subtraction always
    // leaves a result that fits back into W bits.
    always_comb begin
        r_next = trial[W-1:0];
        qbit   = 1'b0;
        if (trial >= {1'b0, d}) begin
            r_next = diff[W-1:0];
            qbit   = 1'b1;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient
// and W-bit remainder, one quotient bit per clock, one division in flight.
//   clk          in   1    clock
//   rst_n        in   1    synchronous active-low reset
//   in_valid     in   1    request valid
//   in_ready     out  1    request can be accepted (IDLE only)
//   dividend     in   2W   unsigned numerator
//   divisor      in   W    unsigned denominator
//   out_valid    out  1    result valid
//   out_ready    in   1    consumer accepts result
//   quotient     out  W    unsigned quotient ('1 on zero divisor / overflow)
//   remainder    out  W    unsigned remainder (low dividend half on zero divisor / overflow)
//   div_by_zero  out  1    divisor was zero
//   overflow     out  1    true quotient would not fit in W bits
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | in_ready=1, waiting for a request
// CALC  | one restoring step per cycle, counter runs W-1 down to 0
// DONE  | out_valid=1, result and flags held until out_ready
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W     = DIV_W,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*W-1:0]   dividend,
    input  logic [W-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     quotient,
    output logic [W-1:0]     remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     r;
    logic [W-1:0]     qsh;
    logic [W-1:0]     d;
    logic [W-1:0]     r_next;
    logic             qbit;
    logic [W-1:0]     qsh_next;

    div_step #(.W(W)) u_step (
        .r      (r),
        .bit_in (qsh[W-1]),
        .d      (d),
        .r_next (r_next),
        .qbit   (qbit)
    );

    // The low dividend half shifts out of the top of qsh while quotient bits
    // fill in from the bottom, so after W steps qsh holds the quotient.
    assign qsh_next = {qsh[W-2:0], qbit};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            r           <= '0;
            qsh         <= '0;
            d           <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        d        <= divisor;
                        r        <= dividend[2*W-1:W];
                        qsh      <= dividend[W-1:0];
                        in_ready <= 1'b0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend[W-1:0];
                            div_by_zero <= 1'b1;
                        end else if (dividend[2*W-1:W] >= divisor) begin
                            // Upper half already >= divisor: quotient needs more than W bits.
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                            overflow  <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_W'(W - 1);
                        end
                    end
                end

                CALC: begin
                    r   <= r_next;
                    qsh <= qsh_next;
                    if (cnt == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= qsh_next;
                        remainder <= r_next;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        div_by_zero <= 1'b0;
                        overflow    <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider: a stimulus process pushes the
// expected response of every accepted request, a monitor pops and compares
// whenever a result is consumed, and also checks latency, hold stability
// under backpressure and the in_ready handshake around each result.
module tb_seq_restoring_divider;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         acc;
        int         lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   rdy_mode = 0;
    logic rdy_force = 1'b1;
    exp_t sb[$];

    seq_restoring_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: out_ready changes just after each rising edge.
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom % 3) != 0;
        else                    out_ready = rdy_force;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division with the saturating special cases.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int acc);
        exp_t e;
        int unsigned lo;
        lo    = a % 256;
        e.acc = acc;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 0) begin
            e.q = 8'hFF; e.r = lo[7:0]; e.dbz = 1'b1; e.lat = 1;
        end else if (a / b > 255) begin
            e.q = 8'hFF; e.r = lo[7:0]; e.ovf = 1'b1; e.lat = 1;
        end else begin
            int unsigned qq, rr;
            qq = a / b;
            rr = a % b;
            e.q = qq[7:0]; e.r = rr[7:0]; e.lat = 9;
        end
        return e;
    endfunction

    // Monitor
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       consumed   = 1'b0;
    logic       first_seen = 1'b0;
    logic [7:0] held_q, held_r;
    logic       held_dbz, held_ovf;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            consumed   = 1'b0;
            first_seen = 1'b0;
        end else begin
            if (consumed) begin
                chk("in_ready_after_consume", 32'(in_ready), 32'd1);
                chk("out_valid_after_consume", 32'(out_valid), 32'd0);
            end
            consumed = 1'b0;
            if (out_valid) begin
                chk("in_ready_while_valid", 32'(in_ready), 32'd0);
                chk("flags_exclusive", 32'(div_by_zero & overflow), 32'd0);
                if (prev_valid && !prev_ready) begin
                    chk("hold_quotient", 32'(quotient), 32'(held_q));
                    chk("hold_remainder", 32'(remainder), 32'(held_r));
                    chk("hold_dbz", 32'(div_by_zero), 32'(held_dbz));
                    chk("hold_ovf", 32'(overflow), 32'(held_ovf));
                end
                chk("queue_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    if (!first_seen) begin
                        chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                        first_seen = 1'b1;
                    end
                    if (out_ready) begin
                        chk("quotient", 32'(quotient), 32'(sb[0].q));
                        chk("remainder", 32'(remainder), 32'(sb[0].r));
                        chk("div_by_zero", 32'(div_by_zero), 32'(sb[0].dbz));
                        chk("overflow", 32'(overflow), 32'(sb[0].ovf));
                        void'(sb.pop_front());
                        consumed   = 1'b1;
                        first_seen = 1'b0;
                    end
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            held_q     = quotient;
            held_r     = remainder;
            held_dbz   = div_by_zero;
            held_ovf   = overflow;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input int unsigned a, input int unsigned b, input bit directed,
                        input logic [7:0] eq, input logic [7:0] er, input bit edbz,
                        input bit eovf, input bit keep);
        int   n;
        exp_t e;
        dividend = a[15:0];
        divisor  = b[7:0];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        if (directed) begin
            e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
            e.acc = cyc + 1;
            e.lat = (edbz || eovf) ? 1 : 9;
        end else begin
            e = model(a, b, cyc + 1);
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin
            in_valid = 1'b0;
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int unsigned a, b;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        send(100, 7, 1, 8'd14, 8'd2, 0, 0, 0);           drain();
        send(65025, 255, 1, 8'd255, 8'd0, 0, 0, 0);      drain();
        send(16'h1234, 0, 1, 8'hFF, 8'h34, 1, 0, 0);     drain();
        send(16'h0900, 8'h08, 1, 8'hFF, 8'h00, 0, 1, 0); drain();

        // Backpressure: result must hold for 5 cycles of out_ready=0.
        rdy_mode  = 2;
        rdy_force = 1'b0;
        @(negedge clk);
        send(1000, 33, 1, 8'd30, 8'd10, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        rdy_force = 1'b1;
        drain();
        rdy_mode = 0;

        // Reset in the 4th CALC cycle discards the division.
        send(5000, 77, 0, 8'd0, 8'd0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        send(200, 9, 1, 8'd22, 8'd2, 0, 0, 0);
        drain();

        // Random traffic with random backpressure, often back-to-back with in_valid held.
        rdy_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            b = ($urandom % 20 == 0) ? 0 : $urandom_range(1, 255);
            if (b != 0 && ($urandom % 4) != 0)
                a = b * $urandom_range(0, 255) + ($urandom % b);
            else
                a = $urandom % 65536;
            send(a, b, 0, 8'd0, 8'd0, 0, 0, ($urandom % 4) != 0);
        end
        in_valid = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
